alu_issue_decoder: RTL

Instruction-side producer for the 64-bit ALU. It accepts 32-bit uPower instruction words over a valid/ready handshake and decodes each one into the ALU control bundle: 4-bit ALU op, ALUSrc, 64-bit extended immediate and register indices. The bundle is buffered in a 2-entry output queue. Branches (BEQ/BNE) are tracked by a small state machine that waits for the ALU zero flag and reports the branch outcome. The block sits between instruction fetch and the register-read/ALU stage.

---
 rtl/alu_dec_pkg.sv | 49 ++++
 rtl/alu_issue_decoder_if.sv | 33 +++
 rtl/alu_dec_fifo2.sv | 39 +++
 rtl/alu_issue_decoder.sv | 117 +++++++++++
 4 files changed

// File: rtl/alu_dec_pkg.sv
// alu_dec_pkg: ALU op codes, uPower opcode/XO constants and the decoded bundle type
package alu_dec_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [5:0] OP_X    = 6'd31;
    localparam logic [5:0] OP_ADDI = 6'd14;
    localparam logic [5:0] OP_ANDI = 6'd28;
    localparam logic [5:0] OP_ORI  = 6'd24;
    localparam logic [5:0] OP_LD   = 6'd58;
    localparam logic [5:0] OP_STD  = 6'd62;
    localparam logic [5:0] OP_BR   = 6'd19;

    localparam logic [8:0] XO_ADD  = 9'd266;
    localparam logic [8:0] XO_SUBF = 9'd40;
    localparam logic [9:0] X_AND   = 10'd28;
    localparam logic [9:0] X_OR    = 10'd444;
    localparam logic [9:0] X_NOR   = 10'd124;
    localparam logic [9:0] X_CMP   = 10'd0;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic        alu_src;
        logic [63:0] ds;
        logic [4:0]  src_a;
        logic [4:0]  src_b;
        logic [4:0]  dest;
        logic        reg_write;
    } dec_bundle_t;

    localparam dec_bundle_t BUNDLE_RST = '{ALU_ADD, 1'b0, 64'd0, 5'd0, 5'd0, 5'd0, 1'b0};
    localparam dec_bundle_t BUNDLE_NOP = '{ALU_ADD, 1'b1, 64'd0, 5'd0, 5'd0, 5'd0, 1'b0};

    function automatic logic [63:0] sext16(input logic [15:0] v);
        return {{48{v[15]}}, v};
    endfunction

    function automatic dec_bundle_t mk(input logic [3:0] op, input logic src, input logic [63:0] d,
                                       input logic [4:0] a, input logic [4:0] b, input logic [4:0] w,
                                       input logic rw);
        return '{op, src, d, a, b, w, rw};
    endfunction

endpackage

// File: rtl/alu_issue_decoder_if.sv
// alu_issue_decoder_if: instruction, decoded-bundle and branch-flag signals of the issue decoder
interface alu_issue_decoder_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_input;
    logic        alu_src;
    logic [63:0] ds;
    logic [4:0]  src_a;
    logic [4:0]  src_b;
    logic [4:0]  dest;
    logic        reg_write;
    logic        flag_valid;
    logic        flag;
    logic        br_valid;
    logic        br_taken;
    logic [63:0] br_offset;
    logic        illegal_valid;

    modport master (
        input  instr_valid, instr, out_ready, flag_valid, flag,
        output instr_ready, out_valid, alu_input, alu_src, ds, src_a, src_b, dest, reg_write,
               br_valid, br_taken, br_offset, illegal_valid
    );

    modport slave (
        output instr_valid, instr, out_ready, flag_valid, flag,
        input  instr_ready, out_valid, alu_input, alu_src, ds, src_a, src_b, dest, reg_write,
               br_valid, br_taken, br_offset, illegal_valid
    );
endinterface

// File: rtl/alu_dec_fifo2.sv
// alu_dec_fifo2: generic 2-entry valid/ready queue; accepts a push while full if the head pops
module alu_dec_fifo2 #(
    parameter type T       = logic,
    parameter T    RST_VAL = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);
    logic [1:0] count_q;
    logic       rd_q;
    T           mem_q [2];
    logic       push, pop;

    assign out_valid_o = count_q != 2'd0;
    assign out_data_o  = mem_q[rd_q];
    assign in_ready_o  = !(count_q == 2'd2 && !out_ready_i);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    // storage, read pointer and occupancy; the write slot is the one after the live entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            rd_q     <= 1'b0;
            mem_q[0] <= RST_VAL;
            mem_q[1] <= RST_VAL;
        end else begin
            if (push) mem_q[rd_q ^ count_q[0]] <= in_data_i;
            if (pop) rd_q <= ~rd_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/alu_issue_decoder.sv
// alu_issue_decoder: uPower instruction decode into ALU bundle, 2-entry output queue, branch FSM
// Optional: define ALU_DEC_ILLEGAL_TRAP_EN to drop illegal instructions and pulse illegal_valid
module alu_issue_decoder
    import alu_dec_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    alu_issue_decoder_if.master bus
);
    typedef enum logic {IDLE, BR_WAIT} state_t;

    state_t      state_q;
    logic        aa_q, br_valid_q, br_taken_q;
    logic [63:0] br_offset_q;
    logic        fifo_ready, accept, push, illegal, is_br, unused_bits;
    dec_bundle_t dec, head;
    logic [5:0]  opc;
    logic [4:0]  f1, f2, f3;
    logic [15:0] si;

    assign opc = bus.instr[31:26];
    assign f1  = bus.instr[25:21];
    assign f2  = bus.instr[20:16];
    assign f3  = bus.instr[15:11];
    assign si  = bus.instr[15:0];

    assign bus.instr_ready = fifo_ready && state_q == IDLE;
    assign accept          = bus.instr_valid && bus.instr_ready;

    // decode; immediate forms leave src_b at 0 except STD, whose store data comes from F1
    always_comb begin
        dec     = BUNDLE_NOP;
        illegal = 1'b0;
        is_br   = 1'b0;
        case (opc)
            OP_X: begin
                if (bus.instr[9:1] == XO_ADD)       dec = mk(ALU_ADD, 1'b0, '0, f2, f3, f1, 1'b1);
                else if (bus.instr[9:1] == XO_SUBF) dec = mk(ALU_SUB, 1'b0, '0, f3, f2, f1, 1'b1);
                else if (bus.instr[10:1] == X_AND)  dec = mk(ALU_AND, 1'b0, '0, f1, f3, f2, 1'b1);
                else if (bus.instr[10:1] == X_OR)   dec = mk(ALU_OR,  1'b0, '0, f1, f3, f2, 1'b1);
                else if (bus.instr[10:1] == X_NOR)  dec = mk(ALU_NOR, 1'b0, '0, f1, f3, f2, 1'b1);
                else if (bus.instr[10:1] == X_CMP)  dec = mk(ALU_SLT, 1'b0, '0, f2, f3, f1, 1'b0);
                else illegal = 1'b1;
            end
            OP_ADDI: dec = mk(ALU_ADD, 1'b1, sext16(si), f2, 5'd0, f1, 1'b1);
            OP_ANDI: dec = mk(ALU_AND, 1'b1, {48'd0, si}, f1, 5'd0, f2, 1'b1);
            OP_ORI:  dec = mk(ALU_OR,  1'b1, {48'd0, si}, f1, 5'd0, f2, 1'b1);
            OP_LD:   dec = mk(ALU_ADD, 1'b1, sext16({si[15:2], 2'b00}), f2, 5'd0, f1, 1'b1);
            OP_STD:  dec = mk(ALU_ADD, 1'b1, sext16({si[15:2], 2'b00}), f2, f1, 5'd0, 1'b0);
            OP_BR: begin
                dec   = mk(ALU_SUB, 1'b0, '0, f1, f2, 5'd0, 1'b0);
                is_br = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

`ifdef ALU_DEC_ILLEGAL_TRAP_EN
    logic illegal_q;
    assign push              = accept && !illegal;
    assign bus.illegal_valid = illegal_q;
    assign unused_bits       = bus.instr[0];
    // one-cycle pulse for each accepted illegal instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_q <= 1'b0;
        else        illegal_q <= accept && illegal;
    end
`else
    assign push              = accept;
    assign bus.illegal_valid = 1'b0;
    assign unused_bits       = bus.instr[0] ^ illegal;
`endif

    alu_dec_fifo2 #(.T(dec_bundle_t), .RST_VAL(BUNDLE_RST)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (push),
        .in_ready_o (fifo_ready),
        .in_data_i  (dec),
        .out_valid_o(bus.out_valid),
        .out_ready_i(bus.out_ready),
        .out_data_o (head)
    );

    assign bus.alu_input = head.alu_op;
    assign bus.alu_src   = head.alu_src;
    assign bus.ds        = head.ds;
    assign bus.src_a     = head.src_a;
    assign bus.src_b     = head.src_b;
    assign bus.dest      = head.dest;
    assign bus.reg_write = head.reg_write;
    assign bus.br_valid  = br_valid_q;
    assign bus.br_taken  = br_taken_q;
    assign bus.br_offset = br_offset_q;

    // branch tracker: latch AA/BD on accept, resolve on the first flag_valid while waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            aa_q        <= 1'b0;
            br_valid_q  <= 1'b0;
            br_taken_q  <= 1'b0;
            br_offset_q <= '0;
        end else begin
            br_valid_q <= 1'b0;
            if (state_q == IDLE && accept && is_br) begin
                state_q     <= BR_WAIT;
                aa_q        <= bus.instr[1];
                br_offset_q <= sext16({si[15:2], 2'b00});
            end else if (state_q == BR_WAIT && bus.flag_valid) begin
                state_q    <= IDLE;
                br_valid_q <= 1'b1;
                br_taken_q <= aa_q ? bus.flag : !bus.flag;
            end
        end
    end
endmodule
